// File: rtl/clock_divider_n_if.sv
// Control/status bundle for clock_divider_n. The en signal exists only when
// CLKDIV_GATE_EN is defined.
interface clock_divider_n_if #(
    parameter int unsigned DIV_W = 8
);
    logic [DIV_W-1:0] div_in;
    logic             div_load;
`ifdef CLKDIV_GATE_EN
    logic             en;
`endif
    logic             out;
    logic             tick;
    logic [DIV_W-1:0] div_active;
    logic             load_pend;
    logic             load_ack;
    logic             div_err;

`ifdef CLKDIV_GATE_EN
    modport master (
        output div_in, div_load, en,
        input  out, tick, div_active, load_pend, load_ack, div_err
    );
    modport slave (
        input  div_in, div_load, en,
        output out, tick, div_active, load_pend, load_ack, div_err
    );
`else
    modport master (
        output div_in, div_load,
        input  out, tick, div_active, load_pend, load_ack, div_err
    );
    modport slave (
        input  div_in, div_load,
        output out, tick, div_active, load_pend, load_ack, div_err
    );
`endif
endinterface

// File: rtl/clock_divider_n.sv
// Runtime-programmable divide-by-N clock divider with 50% duty for any N >= 2.
// Optional CLKDIV_GATE_EN adds an enable that parks the output low at a period boundary.
module clock_divider_n #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic               clk,
    input  logic               reset,
    clock_divider_n_if.slave   bus
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

    logic [DIV_W-1:0] cnt, cnt_d;
    logic [DIV_W-1:0] div_active, div_active_d;
    logic [DIV_W-1:0] pending, pending_d;
    logic             load_pend, load_pend_d;
    logic             load_ack, load_ack_d;
    logic             div_err, div_err_d;
    logic             tick, tick_d;
    logic             out_p, out_p_d;
    logic             out_n;
    logic             at_end;
    logic             boundary;
    logic             valid_load;
    logic             gate_open;

`ifdef CLKDIV_GATE_EN
    assign gate_open = bus.en;
`else
    assign gate_open = 1'b1;
`endif

    // Next-state: counter, divisor reload, load bookkeeping and output phase.
    always_comb begin
        cnt_d        = cnt;
        div_active_d = div_active;
        pending_d    = pending;
        load_pend_d  = load_pend;
        load_ack_d   = 1'b0;
        div_err_d    = 1'b0;

        at_end     = (cnt >= (div_active - ONE));
        boundary   = at_end && gate_open;
        valid_load = bus.div_load && (bus.div_in >= TWO);

        if (boundary) begin
            cnt_d = '0;
            if (load_pend) begin
                div_active_d = pending;
                load_pend_d  = 1'b0;
                load_ack_d   = 1'b1;
            end
        end else if (!at_end) begin
            cnt_d = cnt + ONE;
        end

        // A load landing on a boundary edge is kept pending for the next one.
        if (valid_load) begin
            pending_d   = bus.div_in;
            load_pend_d = 1'b1;
        end else if (bus.div_load) begin
            div_err_d = 1'b1;
        end

        out_p_d = (cnt_d < (div_active_d >> 1));
        tick_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= DEF_DIV - ONE;
            div_active <= DEF_DIV;
            pending    <= DEF_DIV;
            load_pend  <= 1'b0;
            load_ack   <= 1'b0;
            div_err    <= 1'b0;
            tick       <= 1'b0;
            out_p      <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            div_active <= div_active_d;
            pending    <= pending_d;
            load_pend  <= load_pend_d;
            load_ack   <= load_ack_d;
            div_err    <= div_err_d;
            tick       <= tick_d;
            out_p      <= out_p_d;
        end
    end

    // Half-cycle delayed copy of out_p stretches the high phase for odd N.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            out_n <= 1'b0;
        end else begin
            out_n <= out_p;
        end
    end

    assign bus.out        = div_active[0] ? (out_p | out_n) : out_p;
    assign bus.tick       = tick;
    assign bus.div_active = div_active;
    assign bus.load_pend  = load_pend;
    assign bus.load_ack   = load_ack;
    assign bus.div_err    = div_err;

endmodule

// File: tb/tb_clock_divider_n.sv
// Directed self-checking bench for clock_divider_n (default build, gate test when
// CLKDIV_GATE_EN is defined).
module tb_clock_divider_n;

    localparam int unsigned DIV_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    clock_divider_n_if #(.DIV_W(DIV_W)) bus ();

    clock_divider_n #(.DIV_W(DIV_W), .DEFAULT_DIV(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        bus.div_in   = DIV_W'(v);
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
    endtask

    task automatic wait_tick(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (bus.tick) break;
            step();
        end
        if (i == max_cycles) check("wait_tick_timeout", 0, 1);
    endtask

    // Samples out twice per clk across one period starting on a tick cycle.
    task automatic measure(input int n, output int highs, output int edges,
                           output int ticks, output int acks);
        logic prev, s;
        highs = 0; edges = 0; ticks = 0; acks = 0;
        prev = bus.out;
        for (int i = 0; i < n; i++) begin
            s = bus.out;
            if (s) highs++;
            if (i > 0 && s != prev) edges++;
            prev = s;
            if (bus.tick) ticks++;
            if (bus.load_ack) acks++;
            @(negedge clk);
            #1;
            s = bus.out;
            if (s) highs++;
            if (s != prev) edges++;
            prev = s;
            step();
        end
    endtask

    task automatic check_period(input string tag, input int n);
        int h, e, t, a;
        check({tag, "_start_out"}, 32'(bus.out), 1);
        measure(n, h, e, t, a);
        check({tag, "_high_halfcycles"}, 32'(h), 32'(n));
        check({tag, "_edges"}, 32'(e), 1);
        check({tag, "_ticks"}, 32'(t), 1);
        check({tag, "_next_tick"}, 32'(bus.tick), 1);
    endtask

    initial begin
        int h, e, t, a, acc;
        reset        = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
`ifdef CLKDIV_GATE_EN
        bus.en       = 1'b1;
`endif
        step();
        step();
        check("rst_out", 32'(bus.out), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_div_active", 32'(bus.div_active), 3);
        check("rst_load_pend", 32'(bus.load_pend), 0);
        check("rst_load_ack", 32'(bus.load_ack), 0);
        check("rst_div_err", 32'(bus.div_err), 0);

        @(negedge clk);
        #2 reset = 1'b1;
        step();
        check("first_boundary_tick", 32'(bus.tick), 1);
        check_period("n3", 3);

        // Load 4 mid-period.
        step();
        load(4);
        check("l4_pend", 32'(bus.load_pend), 1);
        check("l4_old_div", 32'(bus.div_active), 3);
        check("l4_no_ack_yet", 32'(bus.load_ack), 0);
        step();
        check("l4_ack", 32'(bus.load_ack), 1);
        check("l4_div", 32'(bus.div_active), 4);
        check("l4_pend_clr", 32'(bus.load_pend), 0);
        check_period("n4", 4);
        check("l4_ack_pulse", 32'(bus.load_ack), 0);

        // Back-to-back loads: last one wins, single ack.
        load(5);
        load(7);
        check("l57_pend", 32'(bus.load_pend), 1);
        check("l57_old_div", 32'(bus.div_active), 4);
        step();
        check("l57_no_ack_cnt3", 32'(bus.load_ack), 0);
        step();
        check("l57_ack", 32'(bus.load_ack), 1);
        check("l57_div", 32'(bus.div_active), 7);
        measure(7, h, e, t, a);
        check("n7_high_halfcycles", 32'(h), 7);
        check("n7_edges", 32'(e), 1);
        check("n7_single_ack", 32'(a), 1);

        // Invalid divisors.
        load(1);
        check("err1_pulse", 32'(bus.div_err), 1);
        check("err1_pend", 32'(bus.load_pend), 0);
        load(0);
        check("err0_pulse", 32'(bus.div_err), 1);
        step();
        check("err_clear", 32'(bus.div_err), 0);
        check("err_div_kept", 32'(bus.div_active), 7);
        check("err_pend", 32'(bus.load_pend), 0);

        // Load on the boundary edge applies one period later.
        step(); step(); step();
        load(2);
        check("lb_tick", 32'(bus.tick), 1);
        check("lb_no_ack", 32'(bus.load_ack), 0);
        check("lb_pend", 32'(bus.load_pend), 1);
        check("lb_old_div", 32'(bus.div_active), 7);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            acc += int'(bus.load_ack);
        end
        check("lb_no_early_ack", 32'(acc), 0);
        step();
        check("lb_ack", 32'(bus.load_ack), 1);
        check("lb_div", 32'(bus.div_active), 2);
        check_period("n2", 2);

        // Reload of the same divisor still pends and acks.
        load(2);
        check("same_pend", 32'(bus.load_pend), 1);
        step();
        check("same_ack", 32'(bus.load_ack), 1);
        check("same_div", 32'(bus.div_active), 2);

        // Reset mid-period with a load pending.
        load(6);
        step();
        check("l6_div", 32'(bus.div_active), 6);
        load(8);
        check("pre_rst_out", 32'(bus.out), 1);
        check("pre_rst_pend", 32'(bus.load_pend), 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_out", 32'(bus.out), 0);
        check("midrst_pend", 32'(bus.load_pend), 0);
        check("midrst_div", 32'(bus.div_active), 3);
        check("midrst_tick", 32'(bus.tick), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        step();
        check("rel_tick", 32'(bus.tick), 1);
        measure(3, h, e, t, a);
        check("rel_n3_high", 32'(h), 3);
        check("rel_no_ack", 32'(a), 0);
        check("rel_div", 32'(bus.div_active), 3);

        // Largest divisor.
        load(255);
        wait_tick(10);
        check("n255_ack", 32'(bus.load_ack), 1);
        check("n255_div", 32'(bus.div_active), 255);
        check_period("n255", 255);

`ifdef CLKDIV_GATE_EN
        load(6);
        wait_tick(300);
        check("g_div", 32'(bus.div_active), 6);
        step(); step();
        bus.en = 1'b0;
        step(); step(); step();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acc += int'(bus.out) + int'(bus.tick);
            @(negedge clk);
            #1;
            acc += int'(bus.out);
        end
        check("g_parked_low", 32'(acc), 0);
        bus.en = 1'b1;
        step();
        check("g_restart_tick", 32'(bus.tick), 1);
        check("g_restart_out", 32'(bus.out), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
